// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Timer register map, TCR/TSR bit positions and APB FSM states.
// Revision : 1.0
// ============================================================================
package timer_pkg;

   localparam logic [7:0] c_addr_tdr  = 8'h00;
   localparam logic [7:0] c_addr_tcr  = 8'h01;
   localparam logic [7:0] c_addr_tsr  = 8'h02;
   localparam logic [7:0] c_addr_tcnt = 8'h03;

   localparam int c_tcr_load   = 7;
   localparam int c_tcr_dn     = 5;
   localparam int c_tcr_en     = 4;
   localparam int c_tcr_cks_lo = 0;
   // Implemented TCR bits; 6, 3 and 2 are dropped on write so they read 0
   localparam logic [7:0] c_tcr_mask = 8'hB3;

   localparam int c_tsr_udf = 1;
   localparam int c_tsr_ovf = 0;

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_setup  = 2'd1,
      st_access = 2'd2,
      st_done   = 2'd3
   } apb_state_t;

   // Unmapped addresses and writes to the read-only counter are both errors
   function automatic logic access_err(input logic [7:0] addr, input logic write);
      return (addr > c_addr_tcnt) || (write && (addr == c_addr_tcnt));
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_apb_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_if
// Purpose  : APB slave protocol FSM with one fixed wait state and latched request.
// Revision : 1.0
// ============================================================================
module timer_apb_if
   import timer_pkg::*;
(
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   input  logic [7:0] rdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic       wr_en,
   output logic [7:0] acc_addr,
   output logic [7:0] wr_data
);

   apb_state_t r_state;
   apb_state_t w_state_nxt;
   logic [7:0] r_paddr;
   logic [7:0] r_pwdata;
   logic       r_pwrite;
   logic [7:0] r_prdata;
   logic       r_pready;
   logic       r_pslverr;
   logic       w_setup_entry;
   logic       w_to_done;
   logic       w_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         st_idle: begin
            if (psel && !penable) w_state_nxt = st_setup;
         end
         st_setup: begin
            if (!psel)        w_state_nxt = st_idle;
            else if (penable) w_state_nxt = st_access;
         end
         // A dropped psel in ACCESS abandons the transfer without a response
         st_access: w_state_nxt = psel ? st_done : st_idle;
         st_done:   w_state_nxt = st_idle;
         default:   w_state_nxt = st_idle;
      endcase
   end

   assign w_setup_entry = (r_state == st_idle) && (w_state_nxt == st_setup);
   assign w_to_done     = (w_state_nxt == st_done);
   assign w_err         = access_err(r_paddr, r_pwrite);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state   <= st_idle;
         r_paddr   <= 8'h00;
         r_pwdata  <= 8'h00;
         r_pwrite  <= 1'b0;
         r_prdata  <= 8'h00;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_setup_entry) begin
            r_paddr  <= paddr;
            r_pwdata <= pwdata;
            r_pwrite <= pwrite;
         end
         // Response flops are loaded for the single DONE cycle only
         r_pready  <= w_to_done;
         r_pslverr <= w_to_done && w_err;
         r_prdata  <= (w_to_done && !r_pwrite && !w_err) ? rdata : 8'h00;
      end
   end

   assign prdata   = r_prdata;
   assign pready   = r_pready;
   assign pslverr  = r_pslverr;
   assign wr_en    = (r_state == st_done) && r_pwrite && !w_err;
   assign acc_addr = r_paddr;
   assign wr_data  = r_pwdata;

endmodule
`default_nettype wire

// File: rtl/timer_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_regs
// Purpose  : Timer TDR/TCR/TSR register file behind an APB slave port.
// Revision : 1.0
// ============================================================================
module timer_apb_regs
   import timer_pkg::*;
(
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   output logic [7:0] tdr,
   output logic       tcr_load,
   output logic       tcr_dn,
   output logic       tcr_en,
   output logic [1:0] tcr_cks,
   input  logic [7:0] tcnt,
   input  logic       ovf_set,
   input  logic       udf_set
);

   logic [7:0] r_tdr;
   logic [7:0] r_tcr;
   logic [1:0] r_tsr;
   logic [1:0] w_tsr_nxt;
   logic       w_wr_en;
   logic       w_wr_tsr;
   logic [7:0] w_acc_addr;
   logic [7:0] w_wr_data;
   logic [7:0] w_rdata;

   timer_apb_if u_apb_if (
      .pclk     (pclk),
      .preset   (preset),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .rdata    (w_rdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .wr_en    (w_wr_en),
      .acc_addr (w_acc_addr),
      .wr_data  (w_wr_data)
   );

   always_comb begin
      case (w_acc_addr)
         c_addr_tdr:  w_rdata = r_tdr;
         c_addr_tcr:  w_rdata = r_tcr;
         c_addr_tsr:  w_rdata = {6'b000000, r_tsr};
         c_addr_tcnt: w_rdata = tcnt;
         default:     w_rdata = 8'h00;
      endcase
   end

   assign w_wr_tsr = w_wr_en && (w_acc_addr == c_addr_tsr);

   // Write-0-to-clear, then OR in the event pulses so a same-edge set wins
   always_comb begin
      w_tsr_nxt = r_tsr;
      if (w_wr_tsr) w_tsr_nxt = r_tsr & w_wr_data[1:0];
      w_tsr_nxt[c_tsr_udf] = w_tsr_nxt[c_tsr_udf] | udf_set;
      w_tsr_nxt[c_tsr_ovf] = w_tsr_nxt[c_tsr_ovf] | ovf_set;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_tdr <= 8'h00;
         r_tcr <= 8'h00;
         r_tsr <= 2'b00;
      end else begin
         if (w_wr_en && (w_acc_addr == c_addr_tdr)) r_tdr <= w_wr_data;
         if (w_wr_en && (w_acc_addr == c_addr_tcr)) r_tcr <= w_wr_data & c_tcr_mask;
         r_tsr <= w_tsr_nxt;
      end
   end

   assign tdr      = r_tdr;
   assign tcr_load = r_tcr[c_tcr_load];
   assign tcr_dn   = r_tcr[c_tcr_dn];
   assign tcr_en   = r_tcr[c_tcr_en];
   assign tcr_cks  = r_tcr[c_tcr_cks_lo +: 2];

endmodule
`default_nettype wire
